parity_frame_gen: RTL and testbench

- Parametrised successor to the 4-bit combinational odd-parity cell.
- Accumulates parity over a frame of FRAME_LEN words, each WIDTH bits wide, using a valid/ready stream interface.
- Parity mode (odd/even) is selectable per frame.
- Optional checker mode compares the result against a received parity bit and flags a mismatch.
- Sits between a word source (serialiser/UART-style framer) and a frame sink.

---
 rtl/parity_frame_gen.sv | 118 +++++++++++
 tb/tb_parity_frame_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_gen.sv
// rtl/parity_frame_gen.sv - frame parity generator/checker over a valid/ready word stream
// Folds word parities across a frame, then holds the result until the sink takes it.
module parity_frame_gen #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4,
   parameter int CW        = $clog2(FRAME_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic             odd_sel,
   input  logic             chk_en,
   input  logic             par_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             par_out,
   output logic             err,
   output logic [CW-1:0]    word_cnt
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t        state;
   logic          acc;
   logic          odd_lat;
   logic          chk_lat;
   logic          accept;
   logic          word_par;
   logic          finish;
   logic          nxt_acc;
   logic [CW-1:0] nxt_cnt;
   logic          fin_odd;
   logic          fin_chk;
   logic          par_val;

   assign in_ready = (state != DONE);
   assign accept   = in_valid && in_ready;
   assign word_par = ^data_in;

   // First word of a frame uses the live odd_sel/chk_en since they are only being latched now.
   always_comb begin
      nxt_acc = acc;
      nxt_cnt = word_cnt;
      fin_odd = odd_lat;
      fin_chk = chk_lat;
      finish  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               nxt_acc = word_par;
               nxt_cnt = CW'(1);
               fin_odd = odd_sel;
               fin_chk = chk_en;
               finish  = (FRAME_LEN == 1) || flush;
            end
         end
         ACCUM: begin
            if (accept) begin
               nxt_acc = acc ^ word_par;
               nxt_cnt = word_cnt + CW'(1);
            end
            finish = flush || (accept && (nxt_cnt == CW'(FRAME_LEN)));
         end
         default: ;
      endcase
   end

   assign par_val = nxt_acc ^ fin_odd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= 1'b0;
         word_cnt  <= '0;
         odd_lat   <= 1'b0;
         chk_lat   <= 1'b0;
         out_valid <= 1'b0;
         par_out   <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc      <= nxt_acc;
                  word_cnt <= nxt_cnt;
                  odd_lat  <= odd_sel;
                  chk_lat  <= chk_en;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               acc      <= nxt_acc;
               word_cnt <= nxt_cnt;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= 1'b0;
                  word_cnt  <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // Frame end overrides the IDLE->ACCUM step above.
         if (finish) begin
            par_out   <= par_val;
            err       <= fin_chk & (par_in != par_val);
            out_valid <= 1'b1;
            state     <= DONE;
         end
      end
   end

endmodule

// File: tb/tb_parity_frame_gen.sv
// tb/tb_parity_frame_gen.sv - table-driven, scoreboarded bench for parity_frame_gen
// Frames from a vector table plus hand-written flush, backpressure and reset sequences.
module tb_parity_frame_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] data_in;
   logic       odd_sel;
   logic       chk_en;
   logic       par_in;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic       par_out;
   logic       err;
   logic [2:0] word_cnt;

   parity_frame_gen #(.WIDTH(8), .FRAME_LEN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .odd_sel   (odd_sel),
      .chk_en    (chk_en),
      .par_in    (par_in),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .par_out   (par_out),
      .err       (err),
      .word_cnt  (word_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            odd;
      logic            odd_rest;
      logic            chk;
      logic            chk_rest;
      logic [3:0][7:0] w;
      logic            pin;
      logic            e_par;
      logic            e_err;
   } vec_t;

   typedef struct {
      logic       par;
      logic       err;
      logic [2:0] cnt;
   } exp_t;

   vec_t vt[7];
   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic p, input logic e, input logic [2:0] c);
      exp_t x;
      x.par = p;
      x.err = e;
      x.cnt = c;
      sbq.push_back(x);
   endtask

   task automatic drive_word(input logic [7:0] d, input logic odd, input logic chk,
                             input logic pin, input logic fl);
      int n = 0;
      in_valid = 1'b1;
      data_in  = d;
      odd_sel  = odd;
      chk_en   = chk;
      par_in   = pin;
      flush    = fl;
      while (!in_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) check("ready_timeout", 32'(in_ready), 32'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      data_in  = 8'($urandom);
      odd_sel  = 1'($urandom);
      chk_en   = 1'($urandom);
      par_in   = 1'($urandom);
   endtask

   // Result must be present one cycle after the last accepted word; optionally hold it off first.
   task automatic check_result(input string name, input int hold);
      exp_t e;
      if (sbq.size() == 0) begin
         check({name, "_sb_empty"}, 32'(0), 32'(1));
         return;
      end
      e = sbq.pop_front();
      check({name, "_valid"}, 32'(out_valid), 32'(1));
      check({name, "_par"},   32'(par_out),   32'(e.par));
      check({name, "_err"},   32'(err),       32'(e.err));
      check({name, "_cnt"},   32'(word_cnt),  32'(e.cnt));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         data_in  = 8'($urandom);
         flush    = 1'($urandom);
         @(posedge clk);
         #1;
         check({name, "_hold_ready"}, 32'(in_ready),  32'(0));
         check({name, "_hold_valid"}, 32'(out_valid), 32'(1));
         check({name, "_hold_par"},   32'(par_out),   32'(e.par));
         check({name, "_hold_err"},   32'(err),       32'(e.err));
         check({name, "_hold_cnt"},   32'(word_cnt),  32'(e.cnt));
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, "_rel_valid"}, 32'(out_valid), 32'(0));
      check({name, "_rel_ready"}, 32'(in_ready),  32'(1));
      check({name, "_rel_cnt"},   32'(word_cnt),  32'(0));
   endtask

   task automatic send_frame(input vec_t v, input string name, input int hold);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) push_exp(v.e_par, v.e_err, 3'd4);
         drive_word(v.w[i], (i == 0) ? v.odd : v.odd_rest, (i == 0) ? v.chk : v.chk_rest,
                    (i == 3) ? v.pin : ~v.pin, 1'b0);
      end
      check_result(name, hold);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      //         odd  rest chk  rest words           pin  par  err
      vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00000301, 1'b0, 1'b1, 1'b0};
      vt[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00000301, 1'b0, 1'b0, 1'b0};
      vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000301, 1'b0, 1'b0, 1'b0};
      vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h010000FF, 1'b0, 1'b0, 1'b0};
      vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h010000FF, 1'b1, 1'b0, 1'b1};
      vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hF00F55AA, 1'b1, 1'b0, 1'b1};
      vt[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00000301, 1'b0, 1'b1, 1'b0};
      rv    = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b1, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      data_in   = 8'h00;
      odd_sel   = 1'b0;
      chk_en    = 1'b0;
      par_in    = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #12;
      check("rst_ready", 32'(in_ready),  32'(1));
      check("rst_valid", 32'(out_valid), 32'(0));
      check("rst_cnt",   32'(word_cnt),  32'(0));
      check("rst_par",   32'(par_out),   32'(0));
      check("rst_err",   32'(err),       32'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 7; i++) send_frame(vt[i], $sformatf("vec%0d", i), 0);

      send_frame(vt[0], "backpressure", 5);

      // Flush in ACCUM without a word: par_in taken on the flush cycle.
      drive_word(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
      drive_word(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
      check("flush_mid_cnt", 32'(word_cnt), 32'(2));
      push_exp(1'b0, 1'b1, 3'd2);
      flush  = 1'b1;
      par_in = 1'b1;
      @(posedge clk);
      #1;
      flush  = 1'b0;
      check_result("flush_nowd", 0);

      // Flush together with a word: the word is included.
      drive_word(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
      push_exp(1'b1, 1'b0, 3'd2);
      drive_word(8'h03, 1'b0, 1'b0, 1'b1, 1'b1);
      check_result("flush_wd", 0);

      // Flush in IDLE with no word is ignored.
      flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("flush_idle_valid", 32'(out_valid), 32'(0));
         check("flush_idle_cnt",   32'(word_cnt),  32'(0));
      end
      flush = 1'b0;

      // Flush in IDLE with a word gives a one-word frame.
      push_exp(1'b0, 1'b0, 3'd1);
      drive_word(8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
      check_result("flush_one", 0);

      // Reset mid-frame discards the partial frame immediately.
      drive_word(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      drive_word(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      check("pre_rst_cnt", 32'(word_cnt), 32'(2));
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 32'(in_ready),  32'(1));
      check("mid_rst_valid", 32'(out_valid), 32'(0));
      check("mid_rst_cnt",   32'(word_cnt),  32'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_frame(rv, "post_rst", 0);

      check("sb_drained", 32'(sbq.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
